pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Hazard and forwarding controller for the 5-stage pipeline.
- Sequences the IF/ID and ID/EX pipeline registers by generating PC/IF-ID stalls and IF-ID/ID-EX flushes.
- Produces the rd1_op/rd2_op forwarding selects and the rd1_f/rd2_f forwarded operands consumed at the ID/EX boundary.
- Keeps its own 3-entry scoreboard shadowing EX/MEM/WB destinations, plus saturating stall/flush event counters.

Parameters:
- XLEN, 32, data width of forwarded operands.
- REG_AW, 5, register address width.
- CNT_W, 16, width of event counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- id_rs1  in  REG_AW  source reg 1 of instruction in ID
- id_rs2  in  REG_AW  source reg 2 of instruction in ID
- id_rs1_used  in  1  ID instruction reads rs1
- id_rs2_used  in  1  ID instruction reads rs2
- id_wR  in  REG_AW  ID destination reg
- id_rf_we  in  1  ID instruction writes regfile
- id_is_load  in  1  ID instruction is a DRAM load
- ex_redirect  in  1  branch taken / jump resolved in EX this cycle
- ex_result  in  XLEN  writeback value of EX instruction (non-load)
- mem_result  in  XLEN  final writeback value of MEM instruction (incl. load data)
- wb_result  in  XLEN  writeback value of WB instruction
- stall_pc  out  1  hold PC
- stall_if_id  out  1  hold IF/ID register
- flush_if_id  out  1  clear IF/ID register
- flush_id_ex  out  1  insert bubble into ID/EX
- rd1_op  out  1  select rd1_f into ID/EX
- rd2_op  out  1  select rd2_f into ID/EX
- rd1_f  out  XLEN  forwarded operand 1
- rd2_f  out  XLEN  forwarded operand 2
- stall_cnt  out  CNT_W  load-use stall cycles, saturating
- flush_cnt  out  CNT_W  redirect flush events, saturating

Behaviour:
- Scoreboard: three slots EX, MEM, WB, each holding {valid, wR, is_load}. A slot is a hit for rsN when it is valid, wR==rsN, rsN!=0 and rsN_used.
- Reset (async): all slots invalid; counters 0. With no slot valid and ex_redirect=0, every combinational output is 0.
- Slot update, every posedge:
  - WB<=MEM; MEM<=EX.
  - EX<={id_rf_we, id_wR, id_is_load} when flush_id_ex=0; otherwise EX<=invalid (bubble).
- Load-use hazard: the EX slot is a hit and EX.is_load=1. Result when ex_redirect=0: stall_pc=stall_if_id=flush_id_ex=1 for exactly one cycle. The next cycle the load sits in MEM and is forwarded from mem_result.
- Redirect: ex_redirect=1 gives flush_if_id=flush_id_ex=1 and stall_pc=stall_if_id=0, with load-use suppressed (the ID instruction is on the wrong path). Redirect wins over a simultaneous load-use.
- Forwarding, all combinational, zero latency: per operand, priority EX (non-load) > MEM > WB.
  - rdN_op=1 with rdN_f = ex_result / mem_result / wb_result for the winning stage.
  - No hit, or the only EX hit is a load: rdN_op=0 and rdN_f=0.
  - During a load-use stall rdN_op may assert from an older stage. This is harmless because ID/EX is flushed.
- x0 is never a hazard or forward source.
- Counters:
  - stall_cnt +1 on each cycle with a load-use stall asserted.
  - flush_cnt +1 on each cycle with ex_redirect=1.
  - Both saturate at 2^CNT_W-1 and never wrap.
- Reset mid-operation: all slots invalid and counters 0 immediately; outputs drop per the reset rule above.

Test Plan:
- addi x5 issued (ID rf_we, wR=5), next cycle ID reads rs1=5 with ex_result=0x11 -> rd1_op=1, rd1_f=0x11, no stall.
- lw x6 in EX, ID reads rs2=6 -> stall_pc=stall_if_id=flush_id_ex=1 for one cycle, stall_cnt=1. Next cycle mem_result=0xABCD gives rd2_op=1, rd2_f=0xABCD, no stall.
- Same load-use setup with ex_redirect=1 -> flush_if_id=flush_id_ex=1, stall_pc=0, stall_cnt unchanged, flush_cnt=1. Following cycle the EX slot is invalid.
- x7 written by both the MEM (0x22) and EX (0x33) instructions, ID reads rs1=7 -> rd1_f=0x33. Write to x0 followed by a read of x0 -> rd1_op=0.
- CNT_W=2, five consecutive load-use events -> stall_cnt saturates at 3. Assert rst_n low mid-stall -> counters 0 and all outputs 0 asynchronously.

Source files
------------

// File: rtl/pipe_hazard_if.sv
// rtl/pipe_hazard_if.sv - ID/EX hazard and forwarding bus between pipeline and hazard controller
//
// Purpose: bundles every non-clock/reset signal of pipe_hazard_ctrl.
// Ports (all as interface members):
//   ID side   : id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_wR, id_rf_we, id_is_load
//   EX side   : ex_redirect, ex_result; later stages: mem_result, wb_result
//   controls  : stall_pc, stall_if_id, flush_if_id, flush_id_ex
//   forwarding: rd1_op, rd2_op, rd1_f, rd2_f
//   counters  : stall_cnt, flush_cnt
// Modports: master = pipeline datapath, slave = hazard controller.

interface pipe_hazard_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_rs1_used;
    logic              id_rs2_used;
    logic [REG_AW-1:0] id_wR;
    logic              id_rf_we;
    logic              id_is_load;
    logic              ex_redirect;
    logic [XLEN-1:0]   ex_result;
    logic [XLEN-1:0]   mem_result;
    logic [XLEN-1:0]   wb_result;

    logic              stall_pc;
    logic              stall_if_id;
    logic              flush_if_id;
    logic              flush_id_ex;
    logic              rd1_op;
    logic              rd2_op;
    logic [XLEN-1:0]   rd1_f;
    logic [XLEN-1:0]   rd2_f;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_wR, id_rf_we, id_is_load,
        output ex_redirect, ex_result, mem_result, wb_result,
        input  stall_pc, stall_if_id, flush_if_id, flush_id_ex,
        input  rd1_op, rd2_op, rd1_f, rd2_f, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_wR, id_rf_we, id_is_load,
        input  ex_redirect, ex_result, mem_result, wb_result,
        output stall_pc, stall_if_id, flush_if_id, flush_id_ex,
        output rd1_op, rd2_op, rd1_f, rd2_f, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - load-use stall, redirect flush and operand forwarding for a 5-stage pipeline
//
// Purpose: shadows the EX/MEM/WB destination registers in a 3-slot scoreboard,
// detects load-use hazards and EX redirects, and selects forwarded operands.
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : pipe_hazard_if.slave (ID operands, stage results, stall/flush
//           controls, forwarding selects/operands, saturating event counters)

module pipe_hazard_ctrl #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    pipe_hazard_if.slave bus
);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] wr;
        logic              is_load;
    } slot_t;

    slot_t ex_slot;
    slot_t mem_slot;
    slot_t wb_slot;

    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    logic ex_hit1, mem_hit1, wb_hit1;
    logic ex_hit2, mem_hit2, wb_hit2;
    logic load_use;
    logic stall;
    logic flush_ex;

    // A slot matches an operand only for a real (non-x0) register the ID
    // instruction actually reads.
    function automatic logic slot_hit(input slot_t s, input logic [REG_AW-1:0] rs,
                                      input logic used);
        return s.valid && used && (rs != '0) && (s.wr == rs);
    endfunction

    always_comb begin
        ex_hit1  = slot_hit(ex_slot,  bus.id_rs1, bus.id_rs1_used);
        mem_hit1 = slot_hit(mem_slot, bus.id_rs1, bus.id_rs1_used);
        wb_hit1  = slot_hit(wb_slot,  bus.id_rs1, bus.id_rs1_used);
        ex_hit2  = slot_hit(ex_slot,  bus.id_rs2, bus.id_rs2_used);
        mem_hit2 = slot_hit(mem_slot, bus.id_rs2, bus.id_rs2_used);
        wb_hit2  = slot_hit(wb_slot,  bus.id_rs2, bus.id_rs2_used);
    end

    // A redirect squashes the ID instruction, so its load-use dependency is moot.
    assign load_use = (ex_hit1 || ex_hit2) && ex_slot.is_load;
    assign stall    = load_use && !bus.ex_redirect;
    assign flush_ex = bus.ex_redirect || stall;

    assign bus.stall_pc    = stall;
    assign bus.stall_if_id = stall;
    assign bus.flush_if_id = bus.ex_redirect;
    assign bus.flush_id_ex = flush_ex;

    // An EX hit on a load cannot supply data yet; fall through to older stages.
    // Any stale value picked up that way is discarded by the ID/EX bubble.
    always_comb begin
        bus.rd1_op = 1'b0;
        bus.rd1_f  = '0;
        if (ex_hit1 && !ex_slot.is_load) begin
            bus.rd1_op = 1'b1;
            bus.rd1_f  = bus.ex_result;
        end else if (mem_hit1) begin
            bus.rd1_op = 1'b1;
            bus.rd1_f  = bus.mem_result;
        end else if (wb_hit1) begin
            bus.rd1_op = 1'b1;
            bus.rd1_f  = bus.wb_result;
        end
    end

    always_comb begin
        bus.rd2_op = 1'b0;
        bus.rd2_f  = '0;
        if (ex_hit2 && !ex_slot.is_load) begin
            bus.rd2_op = 1'b1;
            bus.rd2_f  = bus.ex_result;
        end else if (mem_hit2) begin
            bus.rd2_op = 1'b1;
            bus.rd2_f  = bus.mem_result;
        end else if (wb_hit2) begin
            bus.rd2_op = 1'b1;
            bus.rd2_f  = bus.wb_result;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_slot  <= '0;
            mem_slot <= '0;
            wb_slot  <= '0;
        end else begin
            wb_slot  <= mem_slot;
            mem_slot <= ex_slot;
            if (flush_ex) begin
                ex_slot <= '0;
            end else begin
                ex_slot <= '{valid: bus.id_rf_we, wr: bus.id_wR, is_load: bus.id_is_load};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (bus.ex_redirect && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed self-checking bench for pipe_hazard_ctrl

module tb_pipe_hazard_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    pipe_hazard_if #(.XLEN(32), .REG_AW(5), .CNT_W(16)) bus ();
    pipe_hazard_if #(.XLEN(32), .REG_AW(5), .CNT_W(2))  sbus ();

    pipe_hazard_ctrl #(.XLEN(32), .REG_AW(5), .CNT_W(16)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    pipe_hazard_ctrl #(.XLEN(32), .REG_AW(5), .CNT_W(2)) u_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sbus)
    );

    assign sbus.id_rs1      = bus.id_rs1;
    assign sbus.id_rs2      = bus.id_rs2;
    assign sbus.id_rs1_used = bus.id_rs1_used;
    assign sbus.id_rs2_used = bus.id_rs2_used;
    assign sbus.id_wR       = bus.id_wR;
    assign sbus.id_rf_we    = bus.id_rf_we;
    assign sbus.id_is_load  = bus.id_is_load;
    assign sbus.ex_redirect = bus.ex_redirect;
    assign sbus.ex_result   = bus.ex_result;
    assign sbus.mem_result  = bus.mem_result;
    assign sbus.wb_result   = bus.wb_result;

    int checks   = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_id(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                          input logic u2, input logic [4:0] wr, input logic we,
                          input logic ld);
        bus.id_rs1      = rs1;
        bus.id_rs1_used = u1;
        bus.id_rs2      = rs2;
        bus.id_rs2_used = u2;
        bus.id_wR       = wr;
        bus.id_rf_we    = we;
        bus.id_is_load  = ld;
    endtask

    task automatic set_res(input logic redir, input logic [31:0] exr,
                           input logic [31:0] memr, input logic [31:0] wbr);
        bus.ex_redirect = redir;
        bus.ex_result   = exr;
        bus.mem_result  = memr;
        bus.wb_result   = wbr;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ctrl(input string tag, input logic [3:0] exp);
        check_val({tag, "_ctrl"},
                  {60'd0, bus.stall_pc, bus.stall_if_id, bus.flush_if_id, bus.flush_id_ex},
                  {60'd0, exp});
    endtask

    initial begin
        set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        set_res(1'b0, 32'h0, 32'h0, 32'h0);

        // Reset state: everything zero.
        @(negedge clk);
        check_ctrl("reset", 4'b0000);
        check_val("reset_ops", {62'd0, bus.rd1_op, bus.rd2_op}, 64'd0);
        check_val("reset_f", {bus.rd1_f, bus.rd2_f}, 64'd0);
        check_val("reset_cnt", {32'd0, bus.stall_cnt, bus.flush_cnt}, 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // addi x5, then read x5 from EX.
        set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
        next_cycle();
        set_id(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        set_res(1'b0, 32'h11, 32'h0, 32'h0);
        @(negedge clk);
        check_val("ex_fwd_op", {62'd0, bus.rd1_op, bus.rd2_op}, 64'd2);
        check_val("ex_fwd_f", bus.rd1_f, 64'h11);
        check_ctrl("ex_fwd", 4'b0000);
        next_cycle();

        // lw x6, then use x6 as rs2: one stall, then MEM forward.
        set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1);
        set_res(1'b0, 32'h0, 32'h0, 32'h0);
        next_cycle();
        set_id(5'd0, 1'b0, 5'd6, 1'b1, 5'd8, 1'b1, 1'b0);
        @(negedge clk);
        check_ctrl("load_use", 4'b1101);
        next_cycle();
        set_res(1'b0, 32'h0, 32'hABCD, 32'h0);
        @(negedge clk);
        check_ctrl("load_use_after", 4'b0000);
        check_val("load_mem_fwd_op", {63'd0, bus.rd2_op}, 64'd1);
        check_val("load_mem_fwd_f", bus.rd2_f, 64'hABCD);
        check_val("stall_cnt_1", {48'd0, bus.stall_cnt}, 64'd1);
        next_cycle();

        // lw x9 then use with a simultaneous redirect.
        set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1);
        set_res(1'b0, 32'h0, 32'h0, 32'h0);
        next_cycle();
        set_id(5'd9, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0);
        set_res(1'b1, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        check_ctrl("redirect", 4'b0011);
        next_cycle();
        set_id(5'd10, 1'b1, 5'd9, 1'b1, 5'd7, 1'b1, 1'b0);
        set_res(1'b0, 32'h55, 32'h99, 32'h0);
        @(negedge clk);
        check_val("redirect_cnts", {32'd0, bus.stall_cnt, bus.flush_cnt}, {32'd0, 16'd1, 16'd1});
        check_val("redirect_ex_inv", {63'd0, bus.rd1_op}, 64'd0);
        check_val("redirect_rd1_f", bus.rd1_f, 64'd0);
        check_val("redirect_mem_f", {31'd0, bus.rd2_op, bus.rd2_f}, {31'd0, 1'b1, 32'h99});
        next_cycle();

        // x7 in MEM and EX: EX wins; then x0 write/read; then MEM over WB, then WB.
        set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
        set_res(1'b0, 32'h0, 32'h0, 32'h0);
        next_cycle();
        set_id(5'd7, 1'b1, 5'd7, 1'b1, 5'd0, 1'b1, 1'b0);
        set_res(1'b0, 32'h33, 32'h22, 32'h0);
        @(negedge clk);
        check_val("ex_over_mem", {bus.rd1_f, bus.rd2_f}, {32'h33, 32'h33});
        next_cycle();
        set_id(5'd0, 1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0);
        set_res(1'b0, 32'h44, 32'h22, 32'h66);
        @(negedge clk);
        check_val("x0_no_fwd", {31'd0, bus.rd1_op, bus.rd1_f}, 64'd0);
        check_val("mem_over_wb", {31'd0, bus.rd2_op, bus.rd2_f}, {31'd0, 1'b1, 32'h22});
        next_cycle();
        set_id(5'd0, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        check_val("wb_fwd", {31'd0, bus.rd2_op, bus.rd2_f}, {31'd0, 1'b1, 32'h66});
        next_cycle();

        // Five load-use events: 16-bit counter keeps counting, 2-bit one saturates.
        set_res(1'b0, 32'h0, 32'h0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1);
            next_cycle();
            set_id(5'd6, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
            @(negedge clk);
            check_ctrl($sformatf("sat_stall%0d", i), 4'b1101);
            next_cycle();
        end
        @(negedge clk);
        check_val("sat_cnt", {62'd0, sbus.stall_cnt}, 64'd3);
        check_val("wide_cnt", {48'd0, bus.stall_cnt}, 64'd6);
        check_val("sat_flush_cnt", {62'd0, sbus.flush_cnt}, 64'd1);

        // Reset asserted in the middle of a load-use stall.
        next_cycle();
        set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1);
        next_cycle();
        set_id(5'd6, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        check_ctrl("pre_rst_stall", 4'b1101);
        #1 rst_n = 1'b0;
        #1;
        check_ctrl("mid_rst", 4'b0000);
        check_val("mid_rst_cnt", {32'd0, bus.stall_cnt, bus.flush_cnt}, 64'd0);
        check_val("mid_rst_sat_cnt", {60'd0, sbus.stall_cnt, sbus.flush_cnt}, 64'd0);
        check_val("mid_rst_ops", {62'd0, bus.rd1_op, bus.rd2_op}, 64'd0);
        next_cycle();
        rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
